feature_serializer: RTL and testbench

FEATURE_SERIALIZER -- requirements
Module: feature_serializer

---
 rtl/feature_pkg.sv | 47 ++++
 rtl/feature_serializer.sv | 139 +++++++++++++
 tb/tb_feature_serializer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_pkg.sv
// feature_pkg: frame geometry, feature slot map and FSM state type shared by
// feature_serializer. Defining FEAT_SER_CHECKSUM_EN adds the StCheck state.
package feature_pkg;

  localparam int unsigned FEAT_COUNT = 27;
  localparam int unsigned FEAT_W     = 32;
  localparam logic [15:0] MAGIC      = 16'hFEA7;

  // Slot map of the packed feature vector (slot k lives at bits [k*FEAT_W +: FEAT_W])
  localparam int unsigned SlotPsdGamma      = 0;
  localparam int unsigned SlotPsdBeta       = 1;
  localparam int unsigned SlotPsdAlpha      = 2;
  localparam int unsigned SlotPsdTheta      = 3;
  localparam int unsigned SlotPsdDelta      = 4;
  localparam int unsigned SlotPeakAmplitude = 5;
  localparam int unsigned SlotZeroCounter   = 6;
  localparam int unsigned SlotDwtBase       = 7;

  // DWT slots: band-major, four statistics per band, slots 7..26
  localparam int unsigned DwtGamma = 0;
  localparam int unsigned DwtBeta  = 1;
  localparam int unsigned DwtAlpha = 2;
  localparam int unsigned DwtTheta = 3;
  localparam int unsigned DwtDelta = 4;

  localparam int unsigned DwtMax   = 0;
  localparam int unsigned DwtMin   = 1;
  localparam int unsigned DwtMean  = 2;
  localparam int unsigned DwtSum   = 3;
  localparam int unsigned DwtStats = 4;

  function automatic int unsigned dwt_slot(input int unsigned band, input int unsigned stat);
    return SlotDwtBase + band * DwtStats + stat;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
`ifdef FEAT_SER_CHECKSUM_EN
    StPayload,
    StCheck
`else
    StPayload
`endif
  } state_e;

endpackage

// File: rtl/feature_serializer.sv
// feature_serializer: captures a packed feature bundle in one cycle and streams it
// as a header word followed by FEAT_COUNT payload words over a valid/ready link.
// Optional macro FEAT_SER_CHECKSUM_EN appends an XOR checksum word to every frame.
module feature_serializer
  import feature_pkg::*;
#(
  parameter int unsigned FEAT_COUNT = feature_pkg::FEAT_COUNT,
  parameter int unsigned FEAT_W     = feature_pkg::FEAT_W,
  parameter logic [15:0] MAGIC      = feature_pkg::MAGIC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [FEAT_COUNT*FEAT_W-1:0] feat_in,
  input  logic                         feat_valid,
  output logic [31:0]                  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned      IdxW       = (FEAT_COUNT > 1) ? $clog2(FEAT_COUNT) : 1;
  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(FEAT_COUNT - 1);
  localparam logic [IdxW-1:0]  ZeroCntIdx = IdxW'(SlotZeroCounter);

  state_e                       state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [7:0]                   epoch_q, epoch_d;
  logic [FEAT_COUNT*FEAT_W-1:0] feat_q;
  logic                         capture;
  logic                         overrun_q;
  logic [31:0]                  header_word;
  logic [31:0]                  slot_word;

  assign header_word = {MAGIC, 8'(FEAT_COUNT), epoch_q};
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;

  // Select the current payload slot; zero_counter only carries 8 meaningful bits
  always_comb begin
    slot_word = 32'(feat_q[idx_q*FEAT_W +: FEAT_W]);
    if (idx_q == ZeroCntIdx) slot_word = {24'd0, slot_word[7:0]};
  end

`ifdef FEAT_SER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Running XOR of every accepted header/payload word
  always_comb begin
    csum_d = csum_q;
    if (out_valid && out_ready) begin
      if (state_q == StHeader)       csum_d = out_data;
      else if (state_q == StPayload) csum_d = csum_q ^ out_data;
    end
  end

  // Checksum accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  // Next-state logic and output decode; outputs only depend on registered state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    epoch_d   = epoch_q;
    capture   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (feat_valid && en) begin
          capture = 1'b1;
          epoch_d = epoch_q + 8'd1;
          idx_d   = '0;
          state_d = StHeader;
        end
      end
      StHeader: begin
        out_valid = 1'b1;
        out_data  = header_word;
        if (out_ready) state_d = StPayload;
      end
      StPayload: begin
        out_valid = 1'b1;
        out_data  = slot_word;
`ifndef FEAT_SER_CHECKSUM_EN
        out_last  = (idx_q == LastIdx);
`endif
        if (out_ready) begin
          if (idx_q == LastIdx) begin
`ifdef FEAT_SER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StIdle;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FEAT_SER_CHECKSUM_EN
      StCheck: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = csum_q;
        if (out_ready) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Control state; a bundle offered while a frame is in flight is dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      epoch_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      epoch_q   <= epoch_d;
      overrun_q <= feat_valid && en && (state_q != StIdle);
    end
  end

  // Bundle register: only read while busy, so it needs no reset
  always_ff @(posedge clk) begin
    if (capture) feat_q <= feat_in;
  end

endmodule

// File: tb/tb_feature_serializer.sv
// tb_feature_serializer: randomized self-checking bench for feature_serializer.
// A frame-level model builds the expected word list from the bundle and epoch.
module tb_feature_serializer;

  localparam int NF = 27;
`ifdef FEAT_SER_CHECKSUM_EN
  localparam int NWORDS = NF + 2;
`else
  localparam int NWORDS = NF + 1;
`endif

  typedef logic [NF*32-1:0] bundle_t;

  logic        clk, rst, en, feat_valid, out_ready;
  logic        out_valid, out_last, busy, overrun;
  bundle_t     feat_in;
  logic [31:0] out_data;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_epoch;
  logic [31:0] exp_q[$];
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          ovr_cnt, stall_err;
  bit          timed_out, post_valid, post_busy;

  feature_serializer #(
    .FEAT_COUNT(NF),
    .FEAT_W    (32),
    .MAGIC     (16'hFEA7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .feat_in   (feat_in),
    .feat_valid(feat_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bundle_t rand_bundle();
    bundle_t b;
    for (int k = 0; k < NF; k++) b[k*32 +: 32] = $urandom();
    return b;
  endfunction

  // Expected frame: header, slots in order (zero_counter keeps 8 bits), optional XOR
  function automatic void build_frame(input bundle_t b);
    logic [31:0] w;
`ifdef FEAT_SER_CHECKSUM_EN
    logic [31:0] acc;
`endif
    exp_q.delete();
    w = {16'hFEA7, 8'd27, model_epoch};
    exp_q.push_back(w);
`ifdef FEAT_SER_CHECKSUM_EN
    acc = w;
`endif
    for (int k = 0; k < NF; k++) begin
      w = b[k*32 +: 32];
      if (k == 6) w = w & 32'h0000_00FF;
      exp_q.push_back(w);
`ifdef FEAT_SER_CHECKSUM_EN
      acc = acc ^ w;
`endif
    end
`ifdef FEAT_SER_CHECKSUM_EN
    exp_q.push_back(acc);
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; feat_valid = 1'b0; out_ready = 1'b0; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_epoch = 8'd0;
  endtask

  task automatic send_bundle(input bundle_t b);
    @(negedge clk);
    feat_in = b; feat_valid = 1'b1; en = 1'b1;
    model_epoch = model_epoch + 8'd1;
  endtask

  // Collects one frame. mode 0: ready always, 1: toggling, 2: random.
  task automatic recv_frame(input int mode, input int inject_at, input bit inject_en,
                            input bundle_t inj, input bit frame_en);
    int          cyc;
    bit          done, stalled, hold_last;
    logic [31:0] hold_data;
    got_data.delete(); got_last.delete(); got_cyc.delete();
    ovr_cnt = 0; stall_err = 0; cyc = 0; done = 0; stalled = 0;
    hold_data = '0; hold_last = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      feat_valid = 1'b0;
      en = frame_en;
      if (cyc == inject_at) begin
        feat_in = inj; feat_valid = 1'b1; en = inject_en;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (overrun) ovr_cnt++;
      if (stalled && (!out_valid || out_data !== hold_data || out_last !== hold_last))
        stall_err++;
      stalled = 0;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
        if (out_last) done = 1;
      end else if (out_valid) begin
        stalled = 1; hold_data = out_data; hold_last = out_last;
      end
      cyc++;
    end
    timed_out = !done;
    @(negedge clk);
    feat_valid = 1'b0; en = 1'b1; out_ready = 1'b0;
    if (overrun) ovr_cnt++;
    post_valid = out_valid;
    post_busy  = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    rst = 1'b0;
    model_epoch = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    bundle_t b;
    for (int k = 0; k < NF; k++) b[k*32 +: 32] = 32'(k + 1);
    send_bundle(b);
    build_frame(b);
    recv_frame(0, -1, 1'b1, b, 1'b1);
    checks++;
    if (got_data.size() == 0 || got_data[0] !== 32'hFEA7_1B01) begin
      errors++; $display("FAIL ramp_header got=%h want=fea71b01", got_data.size() ? got_data[0] : 'x);
    end
    checks++;
    if (timed_out || got_data.size() != exp_q.size()) begin
      errors++; $display("FAIL ramp_len got=%0d want=%0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1) || got_cyc[i] != i) begin
        errors++;
        $display("FAIL ramp_word[%0d] got=%h last=%b cyc=%0d want=%h last=%b cyc=%0d", i, got_data[i],
                 got_last[i], got_cyc[i], exp_q[i], (i == exp_q.size() - 1), i);
      end
    end
    checks++;
    if (post_busy !== 1'b0 || post_valid !== 1'b0) begin
      errors++; $display("FAIL ramp_end busy=%b valid=%b want 0/0", post_busy, post_valid);
    end
  endtask

  task automatic test_backpressure();
    bundle_t b = rand_bundle();
    send_bundle(b);
    build_frame(b);
    recv_frame(1, -1, 1'b1, b, 1'b1);
    checks++;
    if (timed_out || got_data.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_len got=%0d want=%0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
        errors++; $display("FAIL bp_word[%0d] got=%h/%b want=%h", i, got_data[i], got_last[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stable got=%0d changes want=0", stall_err); end
  endtask

  task automatic test_random_ready();
    for (int f = 0; f < 3; f++) begin
      bundle_t b = rand_bundle();
      send_bundle(b);
      build_frame(b);
      recv_frame(2, -1, 1'b1, b, 1'b1);
      checks++;
      if (timed_out || got_data.size() != exp_q.size() || stall_err != 0) begin
        errors++;
        $display("FAIL rnd_len[%0d] got=%0d stall=%0d want=%0d stall=0", f, got_data.size(), stall_err,
                 exp_q.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
          errors++; $display("FAIL rnd_word[%0d] got=%h/%b want=%h", i, got_data[i], got_last[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_enable();
    bundle_t b = rand_bundle();
    @(negedge clk);
    en = 1'b0; feat_in = rand_bundle(); feat_valid = 1'b1;
    @(negedge clk);
    feat_valid = 1'b0; en = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL en_block busy=%b valid=%b ovr=%b want 0/0/0", busy, out_valid, overrun);
    end
    send_bundle(b);
    build_frame(b);
    recv_frame(0, 8, 1'b0, rand_bundle(), 1'b0);
    checks++;
    if (ovr_cnt != 0) begin errors++; $display("FAIL en_silent got=%0d pulses want=0", ovr_cnt); end
    checks++;
    if (timed_out || got_data.size() != exp_q.size()) begin
      errors++; $display("FAIL en_len got=%0d want=%0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL en_word[%0d] got=%h want=%h", i, got_data[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    bundle_t b1 = rand_bundle();
    bundle_t b2 = rand_bundle();
    logic [31:0] want;
    do_reset();
    send_bundle(b1);
    build_frame(b1);
    recv_frame(0, 5, 1'b1, b2, 1'b1);
    checks++;
    if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_mid got=%0d pulses want=1", ovr_cnt); end
    checks++;
    if (timed_out || got_data.size() != exp_q.size()) begin
      errors++; $display("FAIL ovr_len got=%0d want=%0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovr_word[%0d] got=%h want=%h", i, got_data[i], exp_q[i]);
      end
    end
    // Second frame: drop a bundle in the same cycle the last word is accepted
    b1 = rand_bundle();
    send_bundle(b1);
    build_frame(b1);
    recv_frame(0, NWORDS - 1, 1'b1, b2, 1'b1);
    want = 32'hFEA7_1B02;
    checks++;
    if (got_data.size() == 0 || got_data[0] !== want) begin
      errors++; $display("FAIL ovr_epoch2 got=%h want=%h", got_data.size() ? got_data[0] : 'x, want);
    end
    checks++;
    if (ovr_cnt != 1 || post_valid !== 1'b0 || post_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_last pulses=%0d valid=%b busy=%b want 1/0/0", ovr_cnt, post_valid, post_busy);
    end
    checks++;
    if (got_data.size() != exp_q.size() || got_data[NWORDS-1] !== exp_q[NWORDS-1]) begin
      errors++; $display("FAIL ovr_last_word got_len=%0d want_len=%0d", got_data.size(), exp_q.size());
    end
    send_bundle(b2);
    recv_frame(0, -1, 1'b1, b2, 1'b1);
    want = 32'hFEA7_1B03;
    checks++;
    if (got_data.size() == 0 || got_data[0] !== want) begin
      errors++; $display("FAIL ovr_epoch3 got=%h want=%h", got_data.size() ? got_data[0] : 'x, want);
    end
  endtask

  task automatic test_reset_midframe();
    bundle_t b = rand_bundle();
    int      seen, cyc, idle_bad;
    bit      hit;
    seen = 0; cyc = 0; idle_bad = 0; hit = 0;
    send_bundle(b);
    build_frame(b);
    out_ready = 1'b1;
    while (!hit && cyc < 100) begin
      @(negedge clk);
      feat_valid = 1'b0; cyc++;
      if (seen == 10 && out_valid) hit = 1;
      else if (out_valid && out_ready) seen++;
    end
    checks++;
    if (!hit || out_data !== exp_q[10]) begin
      errors++; $display("FAIL rstmid_pre got=%h want=%h", out_data, exp_q[10]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_last, busy, overrun, out_data} !== 36'h0) begin
      errors++;
      $display("FAIL rstmid_async valid=%b last=%b busy=%b ovr=%b data=%h want all 0", out_valid, out_last,
               busy, overrun, out_data);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    model_epoch = 8'd0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    out_ready = 1'b0;
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL rstmid_idle got=%0d active cycles want=0", idle_bad); end
    b = rand_bundle();
    send_bundle(b);
    build_frame(b);
    recv_frame(0, -1, 1'b1, b, 1'b1);
    checks++;
    if (got_data.size() == 0 || got_data[0] !== 32'hFEA7_1B01) begin
      errors++; $display("FAIL rstmid_header got=%h want=fea71b01", got_data.size() ? got_data[0] : 'x);
    end
    checks++;
    if (timed_out || got_data.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_len got=%0d want=%0d", got_data.size(), exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    do_reset();
    for (int f = 0; f < 256; f++) begin
      bundle_t b = rand_bundle();
      send_bundle(b);
      recv_frame(0, -1, 1'b1, b, 1'b1);
      want = {16'hFEA7, 8'd27, 8'(f + 1)};
      checks++;
      if (timed_out || got_data.size() == 0 || got_data[0] !== want) begin
        errors++;
        $display("FAIL wrap_header[%0d] got=%h want=%h", f, got_data.size() ? got_data[0] : 'x, want);
      end
    end
  endtask

`ifdef FEAT_SER_CHECKSUM_EN
  task automatic test_checksum();
    bundle_t     b = '0;
    logic [31:0] hdr;
    send_bundle(b);
    hdr = {16'hFEA7, 8'd27, model_epoch};
    recv_frame(0, -1, 1'b1, b, 1'b1);
    checks++;
    if (timed_out || got_data.size() != 29) begin
      errors++; $display("FAIL csum_len got=%0d want=29", got_data.size());
    end else begin
      checks++;
      if (got_data[28] !== hdr || got_last[28] !== 1'b1 || got_last[27] !== 1'b0) begin
        errors++;
        $display("FAIL csum_word got=%h last=%b prev_last=%b want=%h 1 0", got_data[28], got_last[28],
                 got_last[27], hdr);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b1; feat_valid = 1'b0; out_ready = 1'b0; feat_in = '0;
    model_epoch = 8'd0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_random_ready();
    test_enable();
    test_overrun();
    test_reset_midframe();
`ifdef FEAT_SER_CHECKSUM_EN
    test_checksum();
`endif
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
